// File: rtl/wm8978_pkg.sv
// Shared types and constants for the WM8978 register scheduler: FSM states,
// codec register addresses, word-length encoding and the register-word layout.
package wm8978_pkg;

  localparam int unsigned I2C_WORD_W = 16;
  localparam int unsigned REG_ADDR_W = 7;
  localparam int unsigned REG_DATA_W = 9;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_ARB,
    ST_RUN_ISSUE,
    ST_RUN_WAIT
  } sched_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } reg_word_t;

  localparam logic [REG_ADDR_W-1:0] R0_SOFT_RESET  = 7'd0;
  localparam logic [REG_ADDR_W-1:0] R1_PWR_MGMT1   = 7'd1;
  localparam logic [REG_ADDR_W-1:0] R2_PWR_MGMT2   = 7'd2;
  localparam logic [REG_ADDR_W-1:0] R3_PWR_MGMT3   = 7'd3;
  localparam logic [REG_ADDR_W-1:0] R4_AUDIO_IF    = 7'd4;
  localparam logic [REG_ADDR_W-1:0] R6_CLK_GEN     = 7'd6;
  localparam logic [REG_ADDR_W-1:0] R7_ADD_CTRL    = 7'd7;
  localparam logic [REG_ADDR_W-1:0] R10_DAC_CTRL   = 7'd10;
  localparam logic [REG_ADDR_W-1:0] R14_ADC_CTRL   = 7'd14;
  localparam logic [REG_ADDR_W-1:0] R44_INPUT_CTRL = 7'd44;
  localparam logic [REG_ADDR_W-1:0] R52_LOUT1_VOL  = 7'd52;
  localparam logic [REG_ADDR_W-1:0] R53_ROUT1_VOL  = 7'd53;
  localparam logic [REG_ADDR_W-1:0] R54_LOUT2_VOL  = 7'd54;
  localparam logic [REG_ADDR_W-1:0] R55_ROUT2_VOL  = 7'd55;

  // R4 WL field: 16/20/24/32-bit samples
  function automatic logic [1:0] wl_to_r4(input int unsigned wl);
    case (wl)
      20:      return 2'b01;
      24:      return 2'b10;
      32:      return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [I2C_WORD_W-1:0] reg_word(input logic [REG_ADDR_W-1:0] addr,
                                                    input logic [REG_DATA_W-1:0] data);
    reg_word_t w;
    w.addr = addr;
    w.data = data;
    return I2C_WORD_W'(w);
  endfunction

endpackage

// File: rtl/wm8978_init_rom.sv
// Power-up register table: soft reset, then master-mode 16-bit I2S with the
// ADC/DAC path and headphone/speaker outputs enabled.
module wm8978_init_rom
  import wm8978_pkg::*;
(
  input  logic [5:0]            index,
  output logic [I2C_WORD_W-1:0] word_c
);

  localparam logic [1:0] R4_WL = wl_to_r4(16);

  always_comb begin
    word_c = '0;
    case (index)
      6'd0:    word_c = reg_word(R0_SOFT_RESET,  9'h000);
      6'd1:    word_c = reg_word(R1_PWR_MGMT1,   9'h01B);
      6'd2:    word_c = reg_word(R2_PWR_MGMT2,   9'h1BF);
      6'd3:    word_c = reg_word(R3_PWR_MGMT3,   9'h06F);
      // BCP=0, LRP=0, WL, FMT=I2S, no channel swaps, stereo
      6'd4:    word_c = reg_word(R4_AUDIO_IF,    {2'b00, R4_WL, 2'b10, 3'b000});
      // MCLK/1, BCLK = MCLK/8, codec is clock master
      6'd5:    word_c = reg_word(R6_CLK_GEN,     9'h00D);
      6'd6:    word_c = reg_word(R7_ADD_CTRL,    9'h000);
      6'd7:    word_c = reg_word(R10_DAC_CTRL,   9'h008);
      6'd8:    word_c = reg_word(R14_ADC_CTRL,   9'h108);
      6'd9:    word_c = reg_word(R44_INPUT_CTRL, 9'h003);
      6'd10:   word_c = reg_word(R52_LOUT1_VOL,  9'h039);
      6'd11:   word_c = reg_word(R53_ROUT1_VOL,  9'h139);
      6'd12:   word_c = reg_word(R54_LOUT2_VOL,  9'h039);
      6'd13:   word_c = reg_word(R55_ROUT2_VOL,  9'h139);
      default: word_c = '0;
    endcase
  end

endmodule

// File: rtl/wm8978_reg_sched.sv
// WM8978 control-plane scheduler: power-up wait, init-table replay, then
// round-robin runtime writes onto one I2C engine with NACK retry.
module wm8978_reg_sched
  import wm8978_pkg::*;
#(
  parameter int unsigned INIT_NUM  = 14,
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [19:0] PWR_DLY   = 20'd500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [I2C_WORD_W-1:0] req0_word,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [I2C_WORD_W-1:0] req1_word,
  output logic                  req1_ready,
  output logic                  i2c_exec,
  output logic [I2C_WORD_W-1:0] i2c_word,
  input  logic                  i2c_done,
  input  logic                  i2c_nack,
  output logic                  init_done,
  output logic                  busy,
  output logic                  cfg_err
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned RTY_W = 3;
  localparam int unsigned CNT_W = 20;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INIT_NUM - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_END  = PWR_DLY - CNT_W'(1);

  sched_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [RTY_W-1:0]      rty_q, rty_d;
  logic                  last_q, last_d;
  logic [I2C_WORD_W-1:0] word_q, word_d;
  logic                  exec_q, exec_d;
  logic                  ready0_q, ready0_d;
  logic                  ready1_q, ready1_d;
  logic                  init_done_q, init_done_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic [I2C_WORD_W-1:0] rom_word_c;
  logic                  retry_c;

  wm8978_init_rom u_rom (
    .index  (idx_q),
    .word_c (rom_word_c)
  );

  assign retry_c = i2c_nack && (rty_q < RTY_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PWR_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      rty_q       <= '0;
      last_q      <= 1'b1;
      word_q      <= '0;
      exec_q      <= 1'b0;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rty_q       <= rty_d;
      last_q      <= last_d;
      word_q      <= word_d;
      exec_q      <= exec_d;
      ready0_q    <= ready0_d;
      ready1_q    <= ready1_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rty_d       = rty_q;
    last_d      = last_q;
    word_d      = word_q;
    exec_d      = 1'b0;
    ready0_d    = 1'b0;
    ready1_d    = 1'b0;
    init_done_d = init_done_q;
    err_d       = err_q;

    case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_INIT_ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_INIT_ISSUE: begin
        word_d  = rom_word_c;
        exec_d  = 1'b1;
        state_d = ST_INIT_WAIT;
      end

      ST_INIT_WAIT: begin
        if (i2c_done) begin
          if (retry_c) begin
            rty_d   = rty_q + RTY_W'(1);
            state_d = ST_INIT_ISSUE;
          end else begin
            rty_d = '0;
            if (i2c_nack) err_d = 1'b1;
            if (idx_q == LAST_IDX) begin
              init_done_d = 1'b1;
              state_d     = ST_ARB;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = ST_INIT_ISSUE;
            end
          end
        end
      end

      // requester 0 wins when alone or when requester 1 was served last
      ST_ARB: begin
        if (req0_valid && (!req1_valid || last_q)) begin
          word_d   = req0_word;
          ready0_d = 1'b1;
          last_d   = 1'b0;
          state_d  = ST_RUN_ISSUE;
        end else if (req1_valid) begin
          word_d   = req1_word;
          ready1_d = 1'b1;
          last_d   = 1'b1;
          state_d  = ST_RUN_ISSUE;
        end
      end

      ST_RUN_ISSUE: begin
        exec_d  = 1'b1;
        state_d = ST_RUN_WAIT;
      end

      ST_RUN_WAIT: begin
        if (i2c_done) begin
          if (retry_c) begin
            rty_d   = rty_q + RTY_W'(1);
            state_d = ST_RUN_ISSUE;
          end else begin
            rty_d = '0;
            if (i2c_nack) err_d = 1'b1;
            state_d = ST_ARB;
          end
        end
      end

      default: state_d = ST_PWR_WAIT;
    endcase

    busy_d = (state_d != ST_ARB);
  end

  assign req0_ready = ready0_q;
  assign req1_ready = ready1_q;
  assign i2c_exec   = exec_q;
  assign i2c_word   = word_q;
  assign init_done  = init_done_q;
  assign busy       = busy_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_wm8978_reg_sched.sv
// Directed bench for wm8978_reg_sched: init replay with retries, held early
// request, round-robin grants and reset during a runtime write.
module tb_wm8978_reg_sched;

  localparam logic [15:0] ROM0 = 16'h0000;
  localparam logic [15:0] ROM1 = 16'h021B;
  localparam logic [15:0] ROM2 = 16'h05BF;
  localparam logic [15:0] ROM3 = 16'h066F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [15:0] req0_word = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_word = '0;
  logic        req1_ready;
  logic        i2c_exec;
  logic [15:0] i2c_word;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic        init_done;
  logic        busy;
  logic        cfg_err;

  int checks = 0;
  int failures = 0;
  logic early_ready = 1'b0;

  logic [15:0] exp_q[$];
  logic        nack_q[$];
  logic [1:0]  grant_q[$];

  always #5 clk = ~clk;

  wm8978_reg_sched #(
    .INIT_NUM  (4),
    .MAX_RETRY (3),
    .PWR_DLY   (20'd10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_word  (req0_word),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_word  (req1_word),
    .req1_ready (req1_ready),
    .i2c_exec   (i2c_exec),
    .i2c_word   (i2c_word),
    .i2c_done   (i2c_done),
    .i2c_nack   (i2c_nack),
    .init_done  (init_done),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_exec"},  32'(i2c_exec), 32'd0);
    chk({tag, "_word"},  32'(i2c_word), 32'd0);
    chk({tag, "_ready"}, 32'({req1_ready, req0_ready}), 32'd0);
    chk({tag, "_init"},  32'(init_done), 32'd0);
    chk({tag, "_err"},   32'(cfg_err), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd1);
  endtask

  task automatic wait_exec(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if ((req0_ready || req1_ready) && !init_done) early_ready = 1'b1;
    end while (!i2c_exec && cyc < 100);
    if (!i2c_exec) chk("exec_timeout", 32'(i2c_exec), 32'd1);
  endtask

  task automatic wait_ready();
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(req0_ready || req1_ready) && cyc < 50);
    if (!(req0_ready || req1_ready)) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic respond(input logic nack);
    i2c_done = 1'b1;
    i2c_nack = nack;
    @(negedge clk);
    chk("exec_one_cycle", 32'(i2c_exec), 32'd0);
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
  endtask

  task automatic run_attempt(input string tag, output int cyc);
    logic [15:0] e;
    logic        n;
    wait_exec(cyc);
    e = exp_q.pop_front();
    n = nack_q.pop_front();
    chk(tag, 32'(i2c_word), 32'(e));
    respond(n);
  endtask

  task automatic push(input logic [15:0] w, input logic n);
    exp_q.push_back(w);
    nack_q.push_back(n);
  endtask

  initial begin
    int cyc;
    logic [1:0] g;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");

    // init: entry 1 NACKed twice, entry 2 NACKed until retries run out
    push(ROM0, 1'b0);
    push(ROM1, 1'b1); push(ROM1, 1'b1); push(ROM1, 1'b0);
    push(ROM2, 1'b1); push(ROM2, 1'b1); push(ROM2, 1'b1); push(ROM2, 1'b1);
    push(ROM3, 1'b0);
    req0_valid = 1'b1;
    req0_word  = 16'hA4FF;
    rst = 1'b0;
    for (int a = 0; a < 9; a++) begin
      if (a == 4) chk("no_err_after_retry_ok", 32'(cfg_err), 32'd0);
      if (a == 8) begin
        chk("err_after_exhaust", 32'(cfg_err), 32'd1);
        chk("init_not_done_yet", 32'(init_done), 32'd0);
      end
      run_attempt("init_word", cyc);
      if (a == 0) chk("first_exec_latency", 32'(cyc), 32'd11);
    end
    chk("init_done", 32'(init_done), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("err_sticky", 32'(cfg_err), 32'd1);
    chk("ready_held_in_init", 32'({early_ready, req0_ready}), 32'd0);

    // held request is granted right after init
    @(negedge clk);
    chk("held_grant", 32'({req1_ready, req0_ready}), 32'b01);
    req0_valid = 1'b0;
    push(16'hA4FF, 1'b0);
    run_attempt("held_word", cyc);
    chk("ready_to_exec", 32'(cyc), 32'd1);

    // round robin: requester 0 was served last, so requester 1 goes first
    req0_valid = 1'b1; req0_word = 16'h1111;
    req1_valid = 1'b1; req1_word = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      grant_q.push_back((i % 2 == 0) ? 2'b10 : 2'b01);
      push((i % 2 == 0) ? 16'h2222 : 16'h1111, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      g = grant_q.pop_front();
      chk("rr_grant", 32'({req1_ready, req0_ready}), 32'(g));
      run_attempt("rr_word", cyc);
      chk("rr_latency", 32'(cyc), 32'd1);
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end

    // reset while a runtime write waits for completion
    req1_valid = 1'b1;
    req1_word  = 16'h3333;
    wait_ready();
    req1_valid = 1'b0;
    push(16'h3333, 1'b0);
    wait_exec(cyc);
    chk("mid_word", 32'(i2c_word), 32'(exp_q.pop_front()));
    void'(nack_q.pop_front());
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    push(ROM0, 1'b0); push(ROM1, 1'b0); push(ROM2, 1'b0); push(ROM3, 1'b0);
    for (int a = 0; a < 4; a++) begin
      run_attempt("replay_word", cyc);
      if (a == 0) chk("replay_latency", 32'(cyc), 32'd11);
    end
    chk("replay_done", 32'(init_done), 32'd1);
    chk("replay_err", 32'(cfg_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not complete");
  end

endmodule
